// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: button synchronisers, four-state run FSM, gated seconds
// prescaler and BCD MM:SS live/lap counters with a frozen-display mux.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    output logic       running,
    output logic       lap_active,
    output logic       tick,
    output logic       overflow,
    output logic [3:0] disp_s0,
    output logic [3:0] disp_s1,
    output logic [3:0] disp_m0,
    output logic [3:0] disp_m1
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, PAUSE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    state_t           state;
    logic             ss_p0, ss_p1, ss_p2, ps;
    logic             lr_p0, lr_p1, lr_p2, pl;
    logic [CNT_W-1:0] presc;
    logic [3:0]       s0, s1, m0, m1;
    logic [3:0]       lap_s0, lap_s1, lap_m0, lap_m1;
    logic [3:0]       s0_nx, s1_nx, m0_nx, m1_nx;
    logic             c0, c1, c2, wrap, en;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

    assign en         = (state == RUN) || (state == LAP);
    assign tick       = en && (presc == TERM);
    assign running    = en;
    assign lap_active = (state == LAP);

    // Carry cascade for one counted second
    assign c0    = (s0 == 4'd9);
    assign c1    = c0 && (s1 == 4'd5);
    assign c2    = c1 && (m0 == 4'd9);
    assign wrap  = c2 && (m1 == 4'd5);
    assign s0_nx = bcd_inc(s0, 4'd9);
    assign s1_nx = c0 ? bcd_inc(s1, 4'd5) : s1;
    assign m0_nx = c1 ? bcd_inc(m0, 4'd9) : m0;
    assign m1_nx = c2 ? bcd_inc(m1, 4'd5) : m1;

    assign disp_s0 = lap_active ? lap_s0 : s0;
    assign disp_s1 = lap_active ? lap_s1 : s1;
    assign disp_m0 = lap_active ? lap_m0 : m0;
    assign disp_m1 = lap_active ? lap_m1 : m1;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ss_p0    <= 1'b0;
            ss_p1    <= 1'b0;
            ss_p2    <= 1'b0;
            ps       <= 1'b0;
            lr_p0    <= 1'b0;
            lr_p1    <= 1'b0;
            lr_p2    <= 1'b0;
            pl       <= 1'b0;
            presc    <= '0;
            s0       <= 4'd0;
            s1       <= 4'd0;
            m0       <= 4'd0;
            m1       <= 4'd0;
            lap_s0   <= 4'd0;
            lap_s1   <= 4'd0;
            lap_m0   <= 4'd0;
            lap_m1   <= 4'd0;
            overflow <= 1'b0;
        end else begin
            // Two-flop synchroniser, edge-detect flop, registered one-shot pulse
            ss_p0 <= btn_start_stop;
            ss_p1 <= ss_p0;
            ss_p2 <= ss_p1;
            ps    <= ss_p1 & ~ss_p2;
            lr_p0 <= btn_lap_reset;
            lr_p1 <= lr_p0;
            lr_p2 <= lr_p1;
            pl    <= lr_p1 & ~lr_p2;

            if (tick) begin
                presc <= '0;
                s0    <= s0_nx;
                s1    <= s1_nx;
                m0    <= m0_nx;
                m1    <= m1_nx;
                if (wrap)
                    overflow <= 1'b1;
            end else if (en) begin
                presc <= presc + 1'b1;
            end

            // start_stop has priority; a coincident lap_reset pulse is dropped
            case (state)
                IDLE: begin
                    if (ps)
                        state <= RUN;
                    else if (pl)
                        overflow <= 1'b0;
                end
                RUN: begin
                    if (ps) begin
                        state <= PAUSE;
                    end else if (pl) begin
                        state  <= LAP;
                        lap_s0 <= s0;
                        lap_s1 <= s1;
                        lap_m0 <= m0;
                        lap_m1 <= m1;
                    end
                end
                LAP: begin
                    if (ps)
                        state <= PAUSE;
                    else if (pl)
                        state <= RUN;
                end
                PAUSE: begin
                    if (ps) begin
                        state <= RUN;
                    end else if (pl) begin
                        state    <= IDLE;
                        presc    <= '0;
                        s0       <= 4'd0;
                        s1       <= 4'd0;
                        m0       <= 4'd0;
                        m1       <= 4'd0;
                        lap_s0   <= 4'd0;
                        lap_s1   <= 4'd0;
                        lap_m0   <= 4'd0;
                        lap_m1   <= 4'd0;
                        overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a seconds-level reference model.
module tb_stopwatch_ctrl;

    localparam int TD      = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_LAP   = 2;
    localparam int S_PAUSE = 3;

    logic       clk_50MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       running, lap_active, tick, overflow;
    logic [3:0] disp_s0, disp_s1, disp_m0, disp_m1;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: whole seconds elapsed, sub-second phase, run state
    int m_state, m_ph, m_sec, m_lap_sec, m_ovf;
    int hss[4];
    int hlr[4];

    stopwatch_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk_50MHz      (clk_50MHz),
        .rst_n          (rst_n),
        .btn_start_stop (btn_ss),
        .btn_lap_reset  (btn_lr),
        .running        (running),
        .lap_active     (lap_active),
        .tick           (tick),
        .overflow       (overflow),
        .disp_s0        (disp_s0),
        .disp_s1        (disp_s1),
        .disp_m0        (disp_m0),
        .disp_m1        (disp_m1)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int to_bcd(input int s);
        return ((s / 600) << 12) | (((s / 60) % 10) << 8) | (((s % 60) / 10) << 4) | (s % 10);
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_ph = 0;
        m_sec = 0;
        m_lap_sec = 0;
        m_ovf = 0;
        for (int i = 0; i < 4; i++) begin
            hss[i] = 0;
            hlr[i] = 0;
        end
    endtask

    task automatic model_edge();
        int ps_i, pl_i, pre, sec_before;
        // A level sampled at edge k acts at edge k+3 if it was low at edge k-1
        ps_i = (hss[2] == 1 && hss[3] == 0) ? 1 : 0;
        pl_i = (hlr[2] == 1 && hlr[3] == 0) ? 1 : 0;
        for (int i = 3; i > 0; i--) begin
            hss[i] = hss[i-1];
            hlr[i] = hlr[i-1];
        end
        hss[0] = int'(btn_ss);
        hlr[0] = int'(btn_lr);

        pre = m_state;
        sec_before = m_sec;
        if (pre == S_RUN || pre == S_LAP) begin
            if (m_ph == TD - 1) begin
                m_ph = 0;
                if (m_sec == 3599) begin
                    m_sec = 0;
                    m_ovf = 1;
                end else begin
                    m_sec++;
                end
            end else begin
                m_ph++;
            end
        end

        if (ps_i == 1) begin
            if (pre == S_IDLE || pre == S_PAUSE) m_state = S_RUN;
            else m_state = S_PAUSE;
        end else if (pl_i == 1) begin
            case (pre)
                S_IDLE: m_ovf = 0;
                S_RUN: begin
                    m_state = S_LAP;
                    m_lap_sec = sec_before;
                end
                S_LAP: m_state = S_RUN;
                default: begin
                    m_state = S_IDLE;
                    m_ph = 0;
                    m_sec = 0;
                    m_lap_sec = 0;
                    m_ovf = 0;
                end
            endcase
        end
    endtask

    task automatic check_all(input string where);
        int e_run, e_lap, e_tick;
        e_run  = (m_state == S_RUN || m_state == S_LAP) ? 1 : 0;
        e_lap  = (m_state == S_LAP) ? 1 : 0;
        e_tick = (e_run == 1 && m_ph == TD - 1) ? 1 : 0;
        chk({where, ".running"}, int'(running), e_run);
        chk({where, ".lap_active"}, int'(lap_active), e_lap);
        chk({where, ".tick"}, int'(tick), e_tick);
        chk({where, ".overflow"}, int'(overflow), m_ovf);
        chk({where, ".disp"}, int'({disp_m1, disp_m0, disp_s1, disp_s0}),
            to_bcd(e_lap == 1 ? m_lap_sec : m_sec));
    endtask

    // Called at posedge+1; drives levels, advances one edge, checks at posedge+1
    task automatic cycle(input logic b_ss, input logic b_lr, input string where);
        btn_ss = b_ss;
        btn_lr = b_lr;
        @(posedge clk_50MHz);
        model_edge();
        #1;
        check_all(where);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk_50MHz);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_50MHz);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Start, then run long enough to wrap past 59:59
        cycle(1'b1, 1'b0, "start");
        cycle(1'b1, 1'b0, "start");
        for (int i = 0; i < 14500; i++) cycle(1'b0, 1'b0, "longrun");
        // Pause, lap_reset back to IDLE clears overflow
        cycle(1'b1, 1'b0, "pause");
        repeat (6) cycle(1'b0, 1'b0, "pause");
        cycle(1'b0, 1'b1, "clear");
        repeat (6) cycle(1'b0, 1'b0, "clear");

        // Held start_stop gives one transition only
        repeat (100) cycle(1'b1, 1'b0, "hold");
        repeat (30) cycle(1'b0, 1'b0, "hold");
        // Lap capture, then both buttons together in RUN
        cycle(1'b0, 1'b1, "lap");
        repeat (30) cycle(1'b0, 1'b0, "lap");
        cycle(1'b0, 1'b1, "unlap");
        repeat (10) cycle(1'b0, 1'b0, "unlap");
        cycle(1'b1, 1'b1, "both");
        repeat (10) cycle(1'b0, 1'b0, "both");

        // Randomized button activity with occasional mid-run reset
        for (int i = 0; i < 8000; i++) begin
            logic nss, nlr;
            nss = btn_ss;
            nlr = btn_lr;
            if ($urandom_range(0, 14) == 0) nss = ~nss;
            if ($urandom_range(0, 14) == 0) nlr = ~nlr;
            if ($urandom_range(0, 49) == 0) begin
                nss = 1'b1;
                nlr = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0)
                do_reset();
            cycle(nss, nlr, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control and timekeeping controller for the stopwatch. It synchronises the two push-buttons and sequences a four-state run FSM. It gates its own seconds prescaler, so a pause preserves sub-second phase, and maintains BCD MM:SS counters with lap-freeze. It sits between the board buttons and the 7-segment display path, and replaces the free-running 1 Hz toggle as the timebase source.

Parameters:
TICK_DIV, 50_000_000, clk_50MHz cycles per one-second tick; legal range 2 and up; benches use 4.
CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk_50MHz  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous, active-low reset
btn_start_stop  input  1  start/stop button, active-high, asynchronous to clk, already debounced
btn_lap_reset  input  1  lap/reset button, active-high, asynchronous to clk, already debounced
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP; display is frozen
tick  output  1  one-cycle pulse on each counted second
overflow  output  1  sticky; set on wrap from 59:59 to 00:00
disp_s0  output  4  displayed seconds ones, BCD 0-9
disp_s1  output  4  displayed seconds tens, BCD 0-5
disp_m0  output  4  displayed minutes ones, BCD 0-9
disp_m1  output  4  displayed minutes tens, BCD 0-5

Behaviour:
- Reset (async assert, sync release): state IDLE. Prescaler, live counters, lap registers, sync flops and overflow are all 0. All outputs are 0.
- Button path: 2-flop synchroniser, then a third flop for rising-edge detect.
  - One press produces one internal pulse, ps (start_stop) or pl (lap_reset).
  - A button sampled high at edge N gives a pulse during the cycle after edge N+2.
  - The state change is visible after edge N+3.
  - Holding a button produces no further pulses.
- FSM states and transitions:
  - IDLE: ps goes to RUN. pl stays in IDLE and clears overflow.
  - RUN: ps goes to PAUSE. pl goes to LAP and captures the live counters into the lap registers on the same edge.
  - LAP: ps goes to PAUSE and releases the freeze, so the display shows the live count. pl goes to RUN and releases the freeze.
  - PAUSE: ps goes to RUN. pl goes to IDLE and clears the prescaler, live counters, lap registers and overflow.
- Simultaneous ps and pl in the same cycle: ps wins and pl is discarded.
- Prescaler:
  - Increments only while the current (pre-edge) state is RUN or LAP.
  - Holds its value in PAUSE; zero in IDLE.
  - When it equals TICK_DIV-1 and is enabled, it returns to 0 on the next edge. tick is high in that cycle (combinational from state and count, or registered with identical timing), and the live counters advance on that same edge.
- Tick and stop coincide: if the prescaler is at terminal while the state is RUN and ps arrives, the tick counts and the state becomes PAUSE on that edge.
- Live counter cascade:
  - s0 wraps 9 to 0 and carries into s1.
  - s1 wraps 5 to 0 and carries into m0.
  - m0 wraps 9 to 0 and carries into m1.
  - m1 wraps 5 to 0.
- Wrap at 59:59: a tick gives 00:00, overflow is set, and counting continues. overflow clears only via pl in IDLE, PAUSE-to-IDLE, or reset.
- Display mux: disp_* shows the lap registers when lap_active is 1, otherwise the live counters, with no extra latency. Live counters keep running during LAP.
- Reset mid-operation: an immediate return to the full reset state. Any partially synchronised press is lost.

Test Plan:
- TICK_DIV=4, reset then press start_stop once: running=1 three edges later. The first tick comes 4 cycles after entering RUN. After 10 ticks, disp = 00:10 (s1=1, s0=0).
- RUN for 2 prescaler counts, pause for 20 cycles, resume: the next tick arrives exactly 2 enabled cycles after resume, proving the prescaler held its phase.
- At 00:07 press lap_reset: disp frozen at 00:07 and lap_active=1. After 5 ticks, press lap_reset again: disp = 00:12 and lap_active=0.
- Force 59:58 in RUN (via ticks or a bench-side preload), then 2 ticks: disp = 00:00, overflow=1 and stays 1. Pause, then press lap_reset: IDLE, disp = 00:00, overflow=0.
- Both buttons rise in the same cycle while in RUN: the state goes to PAUSE, there is no lap capture, and lap_active stays 0. Holding start_stop high for 100 cycles gives exactly one transition.
- Assert rst_n low mid-RUN at 03:27 while lap_active=1: on the same edge all outputs are 0 and the state is IDLE. After release, start_stop is needed to resume.
